// File: rtl/hash_job_scheduler.sv
// Job scheduler for a multi-core double-SHA256 nonce-search engine: queues jobs,
// sequences engine reset/run, and reports found/exhausted/timeout/abort per job.
module hash_job_scheduler #(
  parameter int NUM_CORES      = 10,
  parameter int QDEPTH         = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 33
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [607:0]  job_header,
  input  logic [255:0]  job_target,
  input  logic [31:0]   job_nonce_count,
  input  logic          abort_i,
  output logic          hc_enable,
  output logic          hc_rst,
  output logic [607:0]  hc_block,
  input  logic          hc_round_done,
  input  logic [255:0]  hc_best_hash,
  input  logic [31:0]   hc_best_nonce,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    res_status,
  output logic [255:0]  res_hash,
  output logic [31:0]   res_nonce,
  output logic [31:0]   res_rounds,
  output logic          busy
);

  // state  | meaning
  // IDLE   | waiting for a queued job
  // LOAD   | pop queue head into working registers
  // RESET  | engine held in reset for two cycles
  // RUN    | engine searching, watching rounds/target/timeout/abort
  // REPORT | result held until consumer accepts
  typedef enum logic [2:0] {IDLE, LOAD, RESET, RUN, REPORT} state_t;

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] ST_FOUND = 2'd0, ST_EXHAUST = 2'd1, ST_TIMEOUT = 2'd2, ST_ABORT = 2'd3;

  logic [607:0]   q_hdr [QDEPTH];
  logic [255:0]   q_tgt [QDEPTH];
  logic [31:0]    q_cnt_val [QDEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    q_cnt;
  logic           push, pop;

  state_t         state;
  logic [255:0]   tgt;
  logic [CNT_W-1:0] cnt_lim, covered, covered_next;
  logic [31:0]    rounds, rounds_next;
  logic [TW-1:0]  tmr;
  logic           rst_cnt;
  logic [255:0]   hash_rev;
  logic           hit;

  assign job_ready = (q_cnt != (PW+1)'(QDEPTH));
  assign push      = job_valid && job_ready;
  assign pop       = (state == LOAD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) begin
        q_hdr[wr_ptr]     <= job_header;
        q_tgt[wr_ptr]     <= job_target;
        q_cnt_val[wr_ptr] <= job_nonce_count;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (PW+1)'(1);
        2'b01:   q_cnt <= q_cnt - (PW+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Engine hashes are compared bit-reversed against the target.
  always_comb begin
    hash_rev = '0;
    for (int b = 0; b < 256; b++) hash_rev[255-b] = hc_best_hash[b];
  end

  assign hit          = (hash_rev <= tgt);
  assign covered_next = covered + CNT_W'(NUM_CORES);
  assign rounds_next  = rounds + 32'd1;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= IDLE;
      tgt        <= '0;
      cnt_lim    <= '0;
      covered    <= '0;
      rounds     <= '0;
      tmr        <= '0;
      rst_cnt    <= 1'b0;
      hc_enable  <= 1'b0;
      hc_rst     <= 1'b0;
      hc_block   <= '0;
      res_valid  <= 1'b0;
      res_status <= '0;
      res_hash   <= '0;
      res_nonce  <= '0;
      res_rounds <= '0;
    end else begin
      case (state)
        IDLE: if (q_cnt != '0) state <= LOAD;
        LOAD: begin
          hc_block  <= q_hdr[rd_ptr];
          tgt       <= q_tgt[rd_ptr];
          // A zero count means the full 2^32 nonce space.
          cnt_lim   <= (q_cnt_val[rd_ptr] == 32'd0) ? CNT_W'(64'h1_0000_0000)
                                                    : CNT_W'(q_cnt_val[rd_ptr]);
          rounds    <= '0;
          covered   <= '0;
          rst_cnt   <= 1'b0;
          hc_enable <= 1'b1;
          hc_rst    <= 1'b1;
          state     <= RESET;
        end
        RESET: begin
          if (rst_cnt) begin
            hc_rst <= 1'b0;
            tmr    <= TW'(TIMEOUT_CYCLES - 1);
            state  <= RUN;
          end else begin
            rst_cnt <= 1'b1;
          end
        end
        RUN: begin
          if (hc_round_done) begin
            rounds  <= rounds_next;
            covered <= covered_next;
            tmr     <= TW'(TIMEOUT_CYCLES - 1);
          end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end
          if (abort_i || (hc_round_done && (hit || covered_next >= cnt_lim)) ||
              (!hc_round_done && tmr == '0)) begin
            state      <= REPORT;
            hc_enable  <= 1'b0;
            res_valid  <= 1'b1;
            res_hash   <= hc_best_hash;
            res_nonce  <= hc_best_nonce;
            res_rounds <= hc_round_done ? rounds_next : rounds;
            if (abort_i)                 res_status <= ST_ABORT;
            else if (!hc_round_done)     res_status <= ST_TIMEOUT;
            else if (hit)                res_status <= ST_FOUND;
            else                         res_status <= ST_EXHAUST;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_job_scheduler.sv
// Directed bench for hash_job_scheduler: vector table of single jobs plus
// hand sequences for latency, queue back-pressure, mid-job reset and count=0.
module tb_hash_job_scheduler;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          job_valid;
  logic          job_ready;
  logic [607:0]  job_header;
  logic [255:0]  job_target;
  logic [31:0]   job_nonce_count;
  logic          abort_i;
  logic          hc_enable;
  logic          hc_rst;
  logic [607:0]  hc_block;
  logic          hc_round_done;
  logic [255:0]  hc_best_hash;
  logic [31:0]   hc_best_nonce;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_status;
  logic [255:0]  res_hash;
  logic [31:0]   res_nonce;
  logic [31:0]   res_rounds;
  logic          busy;

  hash_job_scheduler dut (
    .clk(clk), .rst_i(rst_i), .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target), .job_nonce_count(job_nonce_count),
    .abort_i(abort_i), .hc_enable(hc_enable), .hc_rst(hc_rst), .hc_block(hc_block),
    .hc_round_done(hc_round_done), .hc_best_hash(hc_best_hash), .hc_best_nonce(hc_best_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_hash(res_hash), .res_nonce(res_nonce), .res_rounds(res_rounds), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_FOUND = 2'd0, S_EXH = 2'd1, S_TMO = 2'd2, S_ABT = 2'd3;
  localparam logic [255:0] TGT = {8'h00, {248{1'b1}}};
  localparam logic [255:0] ONES = {256{1'b1}};

  typedef struct {
    logic [31:0]  count;
    logic [255:0] target;
    int           pulses;
    logic [255:0] last_rev;
    logic         abort_last;
    logic [1:0]   status;
    logic [31:0]  rounds;
  } vec_t;

  vec_t vecs[10];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] bitrev(input logic [255:0] v);
    logic [255:0] r;
    for (int b = 0; b < 256; b++) r[255-b] = v[b];
    return r;
  endfunction

  function automatic logic [607:0] hdr(input logic [31:0] t);
    return {19{t}};
  endfunction

  task automatic push(input logic [607:0] h, input logic [255:0] t, input logic [31:0] c);
    job_valid = 1'b1; job_header = h; job_target = t; job_nonce_count = c;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_run(input string nm);
    int n = 0;
    while (!hc_rst && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_rst_seen"}, hc_rst, 1'b1);
    while (hc_rst && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_run_en"}, {hc_enable, hc_rst}, 2'b10);
  endtask

  task automatic pulse(input logic [255:0] h, input logic [31:0] nn, input logic ab);
    repeat (2) @(negedge clk);
    hc_round_done = 1'b1; hc_best_hash = h; hc_best_nonce = nn; abort_i = ab;
    @(negedge clk);
    hc_round_done = 1'b0; abort_i = 1'b0;
  endtask

  task automatic wait_res(input string nm);
    int n = 0;
    while (!res_valid && n < 6000) begin @(negedge clk); n++; end
    chk({nm, "_res_seen"}, res_valid, 1'b1);
  endtask

  task automatic handshake(input string nm);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, "_after_hs"}, {res_valid, busy}, 2'b00);
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    push(hdr(32'hC0DE_0000 + i), vecs[i].target, vecs[i].count);
    @(negedge clk);
    wait_run(nm);
    chk({nm, "_block"}, hc_block[255:0], hdr(32'hC0DE_0000 + i));
    if (vecs[i].pulses == 0) begin
      hc_best_hash = bitrev(vecs[i].last_rev);
      hc_best_nonce = 32'hA5A5_0000 + i;
    end
    for (int k = 0; k < vecs[i].pulses; k++) begin
      if (k == vecs[i].pulses - 1)
        pulse(bitrev(vecs[i].last_rev), 32'hA5A5_0000 + i, vecs[i].abort_last);
      else
        pulse(ONES, 32'h1111_0000 + k, 1'b0);
    end
    wait_res(nm);
    chk({nm, "_status"}, res_status, vecs[i].status);
    chk({nm, "_rounds"}, res_rounds, vecs[i].rounds);
    chk({nm, "_hash"}, res_hash, bitrev(vecs[i].last_rev));
    chk({nm, "_nonce"}, res_nonce, 32'hA5A5_0000 + i);
    chk({nm, "_en_off"}, hc_enable, 1'b0);
    handshake(nm);
  endtask

  initial begin
    //            count   target  pulses last_rev               abort status  rounds
    vecs[0] = '{32'd25,  256'h0, 3, 256'h1234,              1'b0, S_EXH,   32'd3};
    vecs[1] = '{32'd100, TGT,    2, {16'h0001, 240'h0},     1'b0, S_FOUND, 32'd2};
    vecs[2] = '{32'd100, TGT,    1, TGT,                    1'b0, S_FOUND, 32'd1};
    vecs[3] = '{32'd10,  TGT,    1, {8'h01, 248'h0},        1'b0, S_EXH,   32'd1};
    vecs[4] = '{32'd100, 256'h5, 1, 256'h1,                 1'b0, S_FOUND, 32'd1};
    vecs[5] = '{32'd10,  256'h5, 1, {1'b1, 255'h0},         1'b0, S_EXH,   32'd1};
    vecs[6] = '{32'd100, TGT,    2, 256'h0,                 1'b1, S_ABT,   32'd2};
    vecs[7] = '{32'd20,  256'h0, 2, 256'h99,                1'b0, S_EXH,   32'd2};
    vecs[8] = '{32'd100, TGT,    0, 256'h77,                1'b0, S_TMO,   32'd0};
    vecs[9] = '{32'd100, 256'h0, 2, 256'h5,                 1'b1, S_ABT,   32'd2};

    rst_i = 1'b1; job_valid = 1'b0; job_header = '0; job_target = '0; job_nonce_count = '0;
    abort_i = 1'b0; hc_round_done = 1'b0; hc_best_hash = '0; hc_best_nonce = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {job_ready, busy, hc_enable, hc_rst, res_valid}, 5'b10000);
    chk("rst_block", hc_block[607:352], 256'h0);
    chk("rst_res", {res_status, res_nonce, res_rounds}, 66'h0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Push-to-hc_rst latency; abort during RESET must be ignored.
    push(hdr(32'h5151_5151), 256'h0, 32'd10);
    @(negedge clk);
    chk("lat_e0", {busy, hc_rst}, 2'b00);
    @(negedge clk);
    chk("lat_e1", {busy, hc_rst}, 2'b10);
    @(negedge clk);
    chk("lat_e2", {hc_enable, hc_rst}, 2'b11);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("lat_e3", {hc_enable, hc_rst}, 2'b11);
    @(negedge clk);
    chk("lat_e4", {hc_enable, hc_rst, res_valid}, 3'b100);
    pulse(ONES, 32'h0000_5151, 1'b0);
    wait_res("lat");
    chk("lat_status", {res_status, res_rounds}, {S_EXH, 32'd1});
    handshake("lat");

    // Queue fills behind a running job; result stalled; queued jobs run in order.
    push(hdr(32'h2121_2121), 256'h0, 32'd10);
    @(negedge clk);
    wait_run("q1");
    push(hdr(32'h2222_2222), 256'h0, 32'd5);
    @(negedge clk);
    chk("q_ready_one", job_ready, 1'b1);
    push(hdr(32'h2323_2323), 256'h0, 32'd7);
    @(negedge clk);
    chk("q_ready_full", job_ready, 1'b0);
    pulse(ONES, 32'h0000_0031, 1'b0);
    wait_res("q1");
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("q_hold%0d", c), {res_valid, hc_enable, job_ready, res_status, res_rounds, res_nonce},
          {3'b100, S_EXH, 32'd1, 32'h0000_0031});
      @(negedge clk);
    end
    chk("q_hold_hash", res_hash, ONES);
    handshake("q1");
    for (int j = 2; j <= 3; j++) begin
      wait_run($sformatf("q%0d", j));
      chk($sformatf("q%0d_block", j), hc_block, hdr(32'h2020_2020 + 32'h0101_0101 * j));
      chk($sformatf("q%0d_ready", j), job_ready, 1'b1);
      pulse(ONES, 32'h0000_0030 + j, 1'b0);
      wait_res($sformatf("q%0d", j));
      chk($sformatf("q%0d_res", j), {res_status, res_rounds, res_nonce}, {S_EXH, 32'd1, 32'h0000_0030 + j});
      handshake($sformatf("q%0d", j));
    end

    // Reset mid-RUN drops the in-flight job and the queued one.
    push(hdr(32'h7777_7777), 256'h0, 32'd10);
    @(negedge clk);
    wait_run("mr");
    push(hdr(32'h7878_7878), 256'h0, 32'd10);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mr_ctrl", {job_ready, busy, hc_enable, hc_rst, res_valid}, 5'b10000);
    chk("mr_block", hc_block[255:0], 256'h0);
    chk("mr_res", {res_status, res_nonce, res_rounds}, 66'h0);
    repeat (6) @(negedge clk);
    chk("mr_quiet", {busy, res_valid, hc_enable}, 3'b000);

    // count=0 means 2^32 nonces; coverage counter pushed near the wrap point.
    push(hdr(32'h0000_0C0C), 256'h0, 32'd0);
    @(negedge clk);
    wait_run("z");
    pulse(ONES, 32'h0000_0001, 1'b0);
    pulse(ONES, 32'h0000_0002, 1'b0);
    chk("z_running", {res_valid, hc_enable}, 2'b01);
    force dut.covered = 33'h0_FFFF_FFEC;
    @(negedge clk);
    release dut.covered;
    pulse(ONES, 32'h0000_0003, 1'b0);
    chk("z_not_yet", {res_valid, hc_enable}, 2'b01);
    pulse(ONES, 32'h0000_0004, 1'b0);
    wait_res("z");
    chk("z_res", {res_status, res_rounds, res_nonce}, {S_EXH, 32'd4, 32'h0000_0004});
    handshake("z");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_job_scheduler.md
Name: hash_job_scheduler

Overview:
Sequences one multi-core double-SHA256 nonce-search engine (10 parallel cores, single best-hash tracker) through a series of mining jobs. Accepts jobs (608-bit header without nonce, 256-bit target, nonce count) through a 2-entry job queue. For each job it resets and enables the engine, counts completed search rounds, and checks the engine's running best hash against the target. It returns one result record per job: found, exhausted, timeout or abort.

Parameters:
NUM_CORES, 10, nonces covered per engine round (engine core count)
QDEPTH, 2, job queue depth (power of 2, >=2)
TIMEOUT_CYCLES, 4096, max cycles between engine round_done pulses before timeout
CNT_W, 33, width of internal nonce-coverage counter

Ports:
clk  in  1  sole clock
rst_i  in  1  synchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  queue can accept
job_header  in  608  block header without nonce
job_target  in  256  success threshold (compared against bit-reversed hash)
job_nonce_count  in  32  nonces to search; 0 means 2^32
abort_i  in  1  cancel current job (pulse)
hc_enable  out  1  engine enable
hc_rst  out  1  engine reset (held high in RESET state)
hc_block  out  608  header to engine, stable for whole job
hc_round_done  in  1  engine pulse: one round of NUM_CORES nonces finished, best_* updated same cycle
hc_best_hash  in  256  engine best hash
hc_best_nonce  in  32  engine best nonce
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_status  out  2  0=FOUND 1=EXHAUSTED 2=TIMEOUT 3=ABORT
res_hash  out  256  best hash at completion
res_nonce  out  32  its nonce
res_rounds  out  32  rounds completed for job
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at a clk edge): queue empty, state IDLE, hc_enable=0, hc_rst=0, hc_block=0, res_valid=0, res_* = 0, busy=0, job_ready=1. Reset takes effect from any state, mid-job included; the in-flight job is dropped without a result.
- Queue: FIFO with pointer wrap. job_ready = !full. A push occurs on job_valid&&job_ready. A simultaneous push and pop when full is not allowed (ready is low). Both push and pop are allowed when 1 <= occupancy < QDEPTH.
- FSM: IDLE -> LOAD -> RESET -> RUN -> REPORT -> IDLE.
- IDLE: if the queue is not empty, pop the head next cycle and go to LOAD.
- LOAD (1 cycle): latch header, target and count into working registers. hc_block takes the header. Clear rounds and the coverage counter. count==0 is stored as 2^32 (CNT_W bits).
- RESET (2 cycles): hc_enable=1, hc_rst=1. Then go to RUN with hc_rst=0.
- RUN: hc_enable=1, hc_rst=0. On each hc_round_done: rounds+=1, covered+=NUM_CORES, timeout counter cleared. Exit priority on the same cycle:
  1. abort_i -> ABORT.
  2. Round done with bitrev(hc_best_hash) <= target -> FOUND. bitrev maps bit b to bit 255-b; the compare is 256-bit unsigned.
  3. Round done with covered_next >= count -> EXHAUSTED. The overshoot of the final round is allowed.
  4. Timeout counter reaches TIMEOUT_CYCLES-1 with no round_done -> TIMEOUT.
- Leaving RUN: hc_enable drops the next cycle. The res_* registers capture hc_best_hash, hc_best_nonce, rounds (post-increment) and status on the exit cycle.
- abort_i outside RUN: ignored.
- REPORT: res_valid=1 and res_* stable until res_ready. After the handshake, res_valid=0 the next cycle and go to IDLE. The engine stays disabled while REPORT is stalled. The queue keeps accepting jobs.
- Latency: a job pushed into an empty queue in IDLE drives hc_rst high 2 cycles after the push edge.
- Back-to-back jobs: minimum gap of 1 IDLE cycle between res handshake and next LOAD.

Test Plan:
- Single job, count=25, target=0: engine pulses round_done 3 times -> EXHAUSTED, res_rounds=3, res_nonce=hc_best_nonce of the 3rd pulse.
- count=100, target=256'h00FF..FF. On round 2, best_hash has bitrev = 256'h0001... -> FOUND, res_rounds=2, hc_enable low the next cycle.
- No round_done for TIMEOUT_CYCLES cycles after RUN entry -> TIMEOUT, res_rounds=0.
- abort_i on the same cycle as a round_done that also meets the target -> ABORT wins, rounds incremented.
- Push 3 jobs with the first running: job_ready=0 after the 2nd queued job. Hold res_ready=0 for 10 cycles: res_* stable, hc_enable=0. Release: jobs 2 and 3 run in order with the correct hc_block.
- rst_i asserted in RUN: all outputs return to reset values the next cycle, queue empty, no result emitted. count=0 job then runs until EXHAUSTED only after ceil(2^32/NUM_CORES) rounds (check the coverage counter wrap in CNT_W bits with a forced counter).
